// File: rtl/data_memory_ctrl.sv
// Word-organised data RAM behind a valid/ready request port with byte/half/word
// access, sign/zero extension, error checking, wait states and zero-fill after reset.
module data_memory_ctrl #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              init_done
);

  localparam int unsigned WC_W  = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam int unsigned FC_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned IDX_W = ADDR_W - 2;

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            state, state_n;
  logic [WC_W-1:0]   wcnt, wcnt_n;
  logic [FC_W-1:0]   fcnt, fcnt_n;
  logic              acc_fire, fill_we;

  logic              lat_we, lat_uns;
  logic [1:0]        lat_size;
  logic [ADDR_W-1:0] lat_addr;
  logic [31:0]       lat_wdata;

  logic              acc_we, acc_uns, acc_err, mem_we;
  logic [1:0]        acc_size, lane;
  logic [ADDR_W-1:0] acc_addr;
  logic [31:0]       acc_wdata, rword, wlane, ld;
  logic [IDX_W-1:0]  widx;
  logic [FC_W-1:0]   midx;
  logic [3:0]        be;
  logic [7:0]        bsel;
  logic [15:0]       hsel;

  logic [31:0] mem [DEPTH];

  assign req_ready = (state == S_IDLE);

  // With no wait states the access happens on the handshake edge, so use live inputs
  assign acc_we    = (WAIT_STATES == 0) ? req_we       : lat_we;
  assign acc_size  = (WAIT_STATES == 0) ? req_size     : lat_size;
  assign acc_uns   = (WAIT_STATES == 0) ? req_unsigned : lat_uns;
  assign acc_addr  = (WAIT_STATES == 0) ? req_addr     : lat_addr;
  assign acc_wdata = (WAIT_STATES == 0) ? req_wdata    : lat_wdata;

  assign widx    = acc_addr[ADDR_W-1:2];
  assign lane    = acc_addr[1:0];
  assign midx    = FC_W'(widx);
  assign rword   = mem[midx];
  assign acc_err = (64'(widx) >= 64'(DEPTH)) || (acc_size == 2'b11) ||
                   ((acc_size == 2'b01) && lane[0]) ||
                   ((acc_size == 2'b10) && (lane != 2'b00));
  assign mem_we  = acc_fire && acc_we && !acc_err;

  always_comb begin
    state_n  = state;
    wcnt_n   = wcnt;
    fcnt_n   = fcnt;
    acc_fire = 1'b0;
    fill_we  = 1'b0;
    case (state)
      S_INIT: begin
        fill_we = 1'b1;
        if (fcnt == FC_W'(DEPTH - 1)) state_n = S_IDLE;
        else                          fcnt_n  = fcnt + 1'b1;
      end
      S_IDLE: begin
        if (req_valid) begin
          if (WAIT_STATES == 0) begin
            acc_fire = 1'b1;
            state_n  = S_RESP;
          end else begin
            wcnt_n  = WC_W'(WAIT_STATES - 1);
            state_n = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (wcnt == '0) begin
          acc_fire = 1'b1;
          state_n  = S_RESP;
        end else begin
          wcnt_n = wcnt - 1'b1;
        end
      end
      S_RESP:  state_n = S_IDLE;
      default: state_n = S_INIT;
    endcase
  end

  // Lane enables / replicated store data, and load extraction with extension
  always_comb begin
    be    = 4'hF;
    wlane = acc_wdata;
    bsel  = rword[{lane, 3'b000} +: 8];
    hsel  = lane[1] ? rword[31:16] : rword[15:0];
    ld    = rword;
    case (acc_size)
      2'b00: begin
        be    = 4'b0001 << lane;
        wlane = {4{acc_wdata[7:0]}};
        ld    = acc_uns ? {24'h0, bsel} : {{24{bsel[7]}}, bsel};
      end
      2'b01: begin
        be    = lane[1] ? 4'b1100 : 4'b0011;
        wlane = {2{acc_wdata[15:0]}};
        ld    = acc_uns ? {16'h0, hsel} : {{16{hsel[15]}}, hsel};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_INIT;
      wcnt      <= '0;
      fcnt      <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      init_done <= 1'b0;
      lat_we    <= 1'b0;
      lat_uns   <= 1'b0;
      lat_size  <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      state     <= state_n;
      wcnt      <= wcnt_n;
      fcnt      <= fcnt_n;
      rsp_valid <= acc_fire;
      if ((state == S_INIT) && (state_n == S_IDLE)) init_done <= 1'b1;
      if (acc_fire) begin
        rsp_err   <= acc_err;
        rsp_rdata <= (acc_err || acc_we) ? 32'h0 : ld;
      end
      if (req_valid && req_ready) begin
        lat_we    <= req_we;
        lat_uns   <= req_unsigned;
        lat_size  <= req_size;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
      end
    end
  end

  // Storage array: zero-fill during INIT, otherwise lane-masked stores
  always_ff @(posedge clk) begin
    if (fill_we) begin
      mem[fcnt] <= '0;
    end else if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[midx][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: two instances (0 and 3 wait states, 16 words) checked
// against a byte-array reference model.
module tb_data_memory_ctrl;

  localparam int DEPTH = 16;

  typedef struct packed {
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] a;
    logic [31:0] wd;
  } op_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst  [2];
  logic        rv   [2];
  logic        rwe  [2];
  logic [1:0]  rsz  [2];
  logic        runs [2];
  logic [31:0] raddr[2];
  logic [31:0] rwd  [2];
  logic        rdy  [2];
  logic        sv   [2];
  logic [31:0] srd  [2];
  logic        serr [2];
  logic        idone[2];

  int nvec = 0;
  int nerr = 0;
  bit [7:0] mb [2][64];

  data_memory_ctrl #(.ADDR_W(32), .DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst[0]), .req_valid(rv[0]), .req_ready(rdy[0]), .req_we(rwe[0]),
    .req_size(rsz[0]), .req_unsigned(runs[0]), .req_addr(raddr[0]), .req_wdata(rwd[0]),
    .rsp_valid(sv[0]), .rsp_rdata(srd[0]), .rsp_err(serr[0]), .init_done(idone[0]));

  data_memory_ctrl #(.ADDR_W(32), .DEPTH(DEPTH), .WAIT_STATES(3)) dut3 (
    .clk(clk), .rst(rst[1]), .req_valid(rv[1]), .req_ready(rdy[1]), .req_we(rwe[1]),
    .req_size(rsz[1]), .req_unsigned(runs[1]), .req_addr(raddr[1]), .req_wdata(rwd[1]),
    .rsp_valid(sv[1]), .rsp_rdata(srd[1]), .rsp_err(serr[1]), .init_done(idone[1]));

  function automatic int ws_of(input int sel);
    return (sel == 1) ? 3 : 0;
  endfunction

  function automatic void model_clear(input int sel);
    for (int i = 0; i < 64; i++) mb[sel][i] = 8'h00;
  endfunction

  // Byte-addressed little-endian memory; returns expected rdata/err and applies stores
  function automatic void model_op(input int sel, input op_t op,
                                   output logic [31:0] ed, output logic ee);
    int nb;
    int ia;
    logic [31:0] v;
    nb = (op.sz == 2'd0) ? 1 : (op.sz == 2'd1) ? 2 : 4;
    ee = (op.sz == 2'd3) || (op.a >= 32'(DEPTH * 4)) || ((op.a % 32'(nb)) != 32'd0);
    ed = 32'h0;
    if (!ee) begin
      ia = int'(op.a[5:0]);
      if (op.we) begin
        for (int i = 0; i < nb; i++) mb[sel][ia + i] = op.wd[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < nb; i++) v = v | (32'(mb[sel][ia + i]) << (8 * i));
        if (!op.uns && nb < 4 && v[8*nb-1]) v = v | (32'hFFFFFFFF << (8 * nb));
        ed = v;
      end
    end
  endfunction

  // Issues one request; reports response data, latency, busy cycles and pulse count
  task automatic do_req(input int sel, input op_t op, output logic [31:0] rd,
                        output logic er, output int lat, output int busy, output int np);
    int k;
    lat = -1; busy = 0; np = 0; rd = 'x; er = 1'bx;
    k = 0;
    @(negedge clk);
    while (rdy[sel] !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (rdy[sel] !== 1'b1) return;
    rv[sel] = 1'b1; rwe[sel] = op.we; rsz[sel] = op.sz; runs[sel] = op.uns;
    raddr[sel] = op.a; rwd[sel] = op.wd;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) begin
        rv[sel] = 1'b0; rwe[sel] = 1'($urandom); rsz[sel] = 2'($urandom);
        runs[sel] = 1'($urandom); raddr[sel] = $urandom; rwd[sel] = $urandom;
      end
      if (sv[sel] === 1'b1) begin
        np++;
        if (lat < 0) begin
          lat = c; rd = srd[sel]; er = serr[sel];
        end
      end
      if (rdy[sel] === 1'b1) break;
      busy++;
    end
  endtask

  task automatic test_reset(input int sel);
    int k;
    bit early;
    repeat (3) @(negedge clk);
    nvec++;
    if ({rdy[sel], sv[sel], srd[sel], serr[sel], idone[sel]} !== 36'h0) begin
      nerr++;
      $display("FAIL reset_state[%0d]: got rdy=%b v=%b rd=%h err=%b done=%b, expected all 0",
               sel, rdy[sel], sv[sel], srd[sel], serr[sel], idone[sel]);
    end
    rst[sel] = 1'b0;
    rv[sel] = 1'b1; rwe[sel] = 1'b1; rsz[sel] = 2'b10; raddr[sel] = 32'h0; rwd[sel] = 32'hFFFFFFFF;
    k = 0; early = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      k = c;
      if (idone[sel] === 1'b1) break;
      if (rdy[sel] !== 1'b0) early = 1'b1;
    end
    rv[sel] = 1'b0;
    model_clear(sel);
    nvec++;
    if (k != DEPTH || early || rdy[sel] !== 1'b1) begin
      nerr++;
      $display("FAIL init_len[%0d]: got done at cycle %0d early_ready=%b ready=%b, expected cycle %0d",
               sel, k, early, rdy[sel], DEPTH);
    end
  endtask

  task automatic test_init_read(input int sel);
    op_t op;
    logic [31:0] rd, ed;
    logic er, ee;
    int lat, busy, np;
    for (int i = 0; i < 3; i++) begin
      op = '{1'b0, 2'b10, 1'b0, 32'($urandom_range(0, DEPTH - 1)) << 2, 32'h0};
      do_req(sel, op, rd, er, lat, busy, np);
      model_op(sel, op, ed, ee);
      nvec++;
      if ({rd, er} !== {ed, ee} || lat != ws_of(sel) + 1) begin
        nerr++;
        $display("FAIL init_read[%0d] a=%h: got %h/%b lat %0d, expected %h/%b lat %0d",
                 sel, op.a, rd, er, lat, ed, ee, ws_of(sel) + 1);
      end
    end
  endtask

  task automatic test_word_ops(input int sel);
    op_t ops[4];
    logic [31:0] rd, ed;
    logic er, ee;
    int lat, busy, np;
    ops[0] = '{1'b1, 2'b10, 1'b0, 32'h8, 32'h12345678};
    ops[1] = '{1'b0, 2'b00, 1'b0, 32'h9, 32'h0};
    ops[2] = '{1'b0, 2'b01, 1'b1, 32'hA, 32'h0};
    ops[3] = '{1'b0, 2'b00, 1'b0, 32'hB, 32'h0};
    for (int i = 0; i < 4; i++) begin
      do_req(sel, ops[i], rd, er, lat, busy, np);
      model_op(sel, ops[i], ed, ee);
      nvec++;
      if ({rd, er} !== {ed, ee} || lat != ws_of(sel) + 1) begin
        nerr++;
        $display("FAIL word_ops[%0d] op%0d: got %h/%b lat %0d, expected %h/%b lat %0d",
                 sel, i, rd, er, lat, ed, ee, ws_of(sel) + 1);
      end
    end
  endtask

  task automatic test_byte_store(input int sel);
    op_t ops[5];
    logic [31:0] rd, ed;
    logic er, ee;
    int lat, busy, np;
    ops[0] = '{1'b1, 2'b10, 1'b0, 32'h4, 32'h0};
    ops[1] = '{1'b1, 2'b00, 1'b0, 32'h4, 32'hABCDEFFF};
    ops[2] = '{1'b0, 2'b10, 1'b0, 32'h4, 32'h0};
    ops[3] = '{1'b0, 2'b00, 1'b0, 32'h4, 32'h0};
    ops[4] = '{1'b0, 2'b00, 1'b1, 32'h4, 32'h0};
    for (int i = 0; i < 5; i++) begin
      do_req(sel, ops[i], rd, er, lat, busy, np);
      model_op(sel, ops[i], ed, ee);
      nvec++;
      if ({rd, er} !== {ed, ee}) begin
        nerr++;
        $display("FAIL byte_store[%0d] op%0d: got %h/%b, expected %h/%b", sel, i, rd, er, ed, ee);
      end
    end
  endtask

  task automatic test_errors(input int sel);
    op_t ops[9];
    logic [31:0] rd, ed;
    logic er, ee;
    int lat, busy, np;
    ops[0] = '{1'b1, 2'b10, 1'b0, 32'h4, 32'h11223344};
    ops[1] = '{1'b1, 2'b10, 1'b0, 32'h0, 32'h55667788};
    ops[2] = '{1'b0, 2'b10, 1'b0, 32'h6, 32'h0};
    ops[3] = '{1'b0, 2'b01, 1'b0, 32'h3, 32'h0};
    ops[4] = '{1'b0, 2'b11, 1'b0, 32'h4, 32'h0};
    ops[5] = '{1'b1, 2'b10, 1'b0, 32'(DEPTH * 4), 32'hDEADBEEF};
    ops[6] = '{1'b1, 2'b01, 1'b0, 32'h5, 32'hCAFE};
    ops[7] = '{1'b0, 2'b10, 1'b0, 32'h4, 32'h0};
    ops[8] = '{1'b0, 2'b10, 1'b0, 32'h0, 32'h0};
    for (int i = 0; i < 9; i++) begin
      do_req(sel, ops[i], rd, er, lat, busy, np);
      model_op(sel, ops[i], ed, ee);
      nvec++;
      if ({rd, er} !== {ed, ee} || np != 1) begin
        nerr++;
        $display("FAIL errors[%0d] op%0d: got %h/%b pulses %0d, expected %h/%b pulses 1",
                 sel, i, rd, er, np, ed, ee);
      end
    end
  endtask

  task automatic test_wait_timing(input int sel);
    op_t op;
    logic [31:0] rd, ed;
    logic er, ee;
    int lat, busy, np;
    for (int i = 0; i < 4; i++) begin
      op = '{(i % 2 == 0), 2'b10, 1'b0, 32'($urandom_range(0, DEPTH - 1)) << 2, $urandom};
      do_req(sel, op, rd, er, lat, busy, np);
      model_op(sel, op, ed, ee);
      nvec++;
      if (lat != ws_of(sel) + 1 || busy != ws_of(sel) + 1 || np != 1 || {rd, er} !== {ed, ee}) begin
        nerr++;
        $display("FAIL wait_timing[%0d] op%0d: got lat %0d busy %0d pulses %0d data %h/%b, expected %0d %0d 1 %h/%b",
                 sel, i, lat, busy, np, rd, er, ws_of(sel) + 1, ws_of(sel) + 1, ed, ee);
      end
    end
  endtask

  task automatic test_back_to_back(input int sel);
    op_t op;
    logic [31:0] ed;
    logic ee;
    int np, first, span;
    bit bad_data;
    op = '{1'b0, 2'b10, 1'b0, 32'h8, 32'h0};
    model_op(sel, op, ed, ee);
    @(negedge clk);
    for (int k = 0; k < 20 && rdy[sel] !== 1'b1; k++) @(negedge clk);
    rv[sel] = 1'b1; rwe[sel] = op.we; rsz[sel] = op.sz; runs[sel] = op.uns;
    raddr[sel] = op.a; rwd[sel] = op.wd;
    np = 0; first = -1; span = 0; bad_data = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (sv[sel] === 1'b1) begin
        np++;
        if (first < 0) first = c;
        span = c - first;
        if ({srd[sel], serr[sel]} !== {ed, ee}) bad_data = 1'b1;
      end
      if (c == 15) rv[sel] = 1'b0;
    end
    nvec++;
    if (np != 3 || first != ws_of(sel) + 1 || span != 2 * (ws_of(sel) + 2) || bad_data) begin
      nerr++;
      $display("FAIL back_to_back[%0d]: got pulses %0d first %0d span %0d bad_data %b, expected 3 %0d %0d 0",
               sel, np, first, span, bad_data, ws_of(sel) + 1, 2 * (ws_of(sel) + 2));
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid(input int sel);
    op_t op;
    logic [31:0] rd, ed;
    logic er, ee;
    int lat, busy, np, k;
    bit seen;
    @(negedge clk);
    for (int j = 0; j < 20 && rdy[sel] !== 1'b1; j++) @(negedge clk);
    rv[sel] = 1'b1; rwe[sel] = 1'b1; rsz[sel] = 2'b10; runs[sel] = 1'b0;
    raddr[sel] = 32'h20; rwd[sel] = 32'hDEADBEEF;
    @(negedge clk);
    rv[sel] = 1'b0;
    rst[sel] = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (sv[sel] !== 1'b0) seen = 1'b1;
    end
    rst[sel] = 1'b0;
    k = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      k = c;
      if (sv[sel] !== 1'b0) seen = 1'b1;
      if (idone[sel] === 1'b1) break;
    end
    model_clear(sel);
    nvec++;
    if (seen || k != DEPTH) begin
      nerr++;
      $display("FAIL reset_mid[%0d]: got stray_rsp %b reinit %0d, expected 0 %0d", sel, seen, k, DEPTH);
    end
    op = '{1'b0, 2'b10, 1'b0, 32'h20, 32'h0};
    do_req(sel, op, rd, er, lat, busy, np);
    model_op(sel, op, ed, ee);
    nvec++;
    if ({rd, er} !== {ed, ee}) begin
      nerr++;
      $display("FAIL reset_mid_read[%0d]: got %h/%b, expected %h/%b", sel, rd, er, ed, ee);
    end
  endtask

  task automatic test_random(input int sel, input int n);
    op_t op;
    logic [31:0] rd, ed;
    logic er, ee;
    int lat, busy, np;
    for (int i = 0; i < n; i++) begin
      op.we  = 1'($urandom);
      op.sz  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      op.uns = 1'($urandom);
      op.a   = 32'($urandom_range(0, DEPTH * 4 + 7));
      op.wd  = $urandom;
      do_req(sel, op, rd, er, lat, busy, np);
      model_op(sel, op, ed, ee);
      nvec++;
      if ({rd, er} !== {ed, ee} || lat != ws_of(sel) + 1 || np != 1) begin
        nerr++;
        $display("FAIL random[%0d] #%0d we=%b sz=%0d u=%b a=%h: got %h/%b lat %0d, expected %h/%b lat %0d",
                 sel, i, op.we, op.sz, op.uns, op.a, rd, er, lat, ed, ee, ws_of(sel) + 1);
      end
    end
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      rst[s] = 1'b1; rv[s] = 1'b0; rwe[s] = 1'b0; rsz[s] = 2'b00; runs[s] = 1'b0;
      raddr[s] = 32'h0; rwd[s] = 32'h0;
      model_clear(s);
    end
    test_reset(0);
    test_reset(1);
    test_init_read(0);
    test_init_read(1);
    test_word_ops(0);
    test_byte_store(0);
    test_errors(0);
    test_errors(1);
    test_wait_timing(1);
    test_wait_timing(0);
    test_back_to_back(1);
    test_random(0, 60);
    test_random(1, 40);
    test_reset_mid(1);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/data_memory_ctrl.md
Name: data_memory_ctrl

Overview:
- Parametrised successor to the single-cycle data memory: word-organised RAM behind a valid/ready request port with a one-cycle response pulse.
- Adds byte/half/word loads and stores, sign/zero extension, alignment and range checking, configurable wait states, and a hardware zero-fill after reset.
- Sits between the datapath load/store unit and the data store. The datapath stalls on req_ready/rsp_valid.

Parameters:
ADDR_W, 32, byte-address width of req_addr.
DEPTH, 1024, number of 32-bit words (>=2, power of two not required).
WAIT_STATES, 0, extra cycles between request acceptance and memory access (0..15).

Ports:
clk  in  1  clock, all state updates on rising edge.
rst  in  1  asynchronous, active-high reset.
req_valid  in  1  request present.
req_ready  out  1  controller can accept; high only in IDLE.
req_we  in  1  1=store, 0=load.
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
req_unsigned  in  1  loads only: 1 zero-extend, 0 sign-extend; ignored for word and stores.
req_addr  in  ADDR_W  byte address.
req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
rsp_valid  out  1  one-cycle response pulse.
rsp_rdata  out  32  load result; 0 for stores and errors.
rsp_err  out  1  qualified by rsp_valid: misaligned, out-of-range or illegal size.
init_done  out  1  zero-fill finished; stays high until next reset.

Behaviour:
- Reset (asynchronous):
  - State goes to INIT with the fill counter at 0.
  - req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_done=0.
- INIT:
  - Each rising edge writes 0 to word[cnt] and increments cnt.
  - The edge that writes word DEPTH-1 moves the state to IDLE and sets init_done=1.
  - Fill takes exactly DEPTH edges after rst deasserts.
  - req_valid is ignored.
- IDLE:
  - req_ready=1, decoded combinationally from state.
  - A handshake edge (req_valid && req_ready) latches we, size, unsigned, addr and wdata.
  - Next state is WAIT with counter=WAIT_STATES-1, or RESP directly when WAIT_STATES=0.
  - When WAIT_STATES=0, the memory access happens on the handshake edge itself.
- WAIT:
  - The counter decrements each edge.
  - The edge where the counter is 0 performs the access and enters RESP.
  - Access edge = handshake edge + WAIT_STATES.
- RESP:
  - rsp_valid=1 for exactly one cycle, with registered rsp_rdata and rsp_err.
  - Next edge returns to IDLE and clears rsp_valid; rsp_rdata and rsp_err hold their values.
  - Back-to-back requests are spaced WAIT_STATES+2 cycles apart.
- Address decode:
  - Word index = addr[ADDR_W-1:2]; byte lane = addr[1:0].
  - Error if any of: word index >= DEPTH; size=01 with addr[0]=1; size=10 with addr[1:0]!=0; size=11.
  - An errored request performs no write and returns rdata=0, rsp_err=1.
- Stores (little-endian):
  - Byte writes wdata[7:0] into lane addr[1:0].
  - Half writes wdata[15:0] into lanes {addr[1],0} and {addr[1],1}.
  - Word writes all 32 bits.
  - Unaddressed lanes are preserved.
  - rsp_rdata=0, rsp_err=0.
- Loads:
  - The selected byte or half is extracted and extended per req_unsigned; word loads are returned unchanged.
  - Read data reflects all stores whose access edge is earlier.
- Reset mid-operation:
  - A request not yet at its access edge is dropped with no write and no response.
  - Memory is zero-filled again.
- Arithmetic:
  - Wait and fill counters are sized clog2(WAIT_STATES+1) and clog2(DEPTH), minimum 1 bit.
  - Neither counter wraps.

Test Plan:
- DEPTH=16, release rst -> req_ready=0 for 16 cycles, init_done and req_ready rise on edge 16; LW of any word -> 0x00000000.
- WAIT_STATES=0: SW 0x12345678 @0x8, then LB @0x9 signed -> 0x00000056; LH @0xA unsigned -> 0x00001234; LB @0xB -> 0x00000012.
- SB 0xFF @0x4 onto a word holding 0x00000000, then LW @0x4 -> 0x000000FF; LB @0x4 signed -> 0xFFFFFFFF; LBU -> 0x000000FF.
- Errors: LW @0x6, LH @0x3, size=11, SW @(DEPTH*4) -> each gives rsp_err=1 and rsp_rdata=0; a follow-up LW shows target words unchanged.
- WAIT_STATES=3: handshake at edge N -> rsp_valid high only in the cycle after edge N+3, req_ready low for 4 cycles; req_valid held high throughout is accepted once per 5 cycles.
- Store accepted, rst pulsed before its access edge -> no rsp_valid; after re-init, LW at that address -> 0x00000000.
